window_min_max: RTL

Streaming extremum tracker for 4-bit unsigned samples. Accepts a stream of samples over a valid/ready handshake, tracks the running minimum and maximum over a fixed window of WINDOW samples, then presents the window's min, max and a flat flag over a second valid/ready handshake. It sits downstream of the sample source as the sequential consumer of the 4-bit comparison path used elsewhere in the design.

---
 rtl/window_min_max_pkg.sv | 12 +
 rtl/window_min_max_minmax4.sv | 17 +
 rtl/window_min_max.sv | 122 ++++++++++++
 3 files changed

// File: rtl/window_min_max_pkg.sv
// Shared constants for the windowed min/max tracker: state encoding,
// sample width and the legal range of the WINDOW parameter.
package window_min_max_pkg;

    localparam int SAMPLE_W   = 4;
    localparam int WINDOW_MIN = 2;
    localparam int WINDOW_MAX = 16;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

endpackage

// File: rtl/window_min_max_minmax4.sv
// Combinational unsigned comparator returning the smaller and larger of
// two samples; equal inputs give lo = hi = a.
module minmax4
    import window_min_max_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic [SAMPLE_W-1:0] lo,
    output logic [SAMPLE_W-1:0] hi
);

    always_comb begin
        lo = (b < a) ? b : a;
        hi = (b > a) ? b : a;
    end

endmodule

// File: rtl/window_min_max.sv
// Streaming tracker: collects WINDOW samples, then presents the window's
// min, max and flat flag until the downstream handshake completes.
module window_min_max
    import window_min_max_pkg::*;
#(
    parameter int WINDOW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [SAMPLE_W-1:0] out_min,
    output logic [SAMPLE_W-1:0] out_max,
    output logic                out_flat,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int              CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] run_min_q, run_min_d;
    logic [SAMPLE_W-1:0] run_max_q, run_max_d;
    logic [SAMPLE_W-1:0] out_min_q, out_min_d;
    logic [SAMPLE_W-1:0] out_max_q, out_max_d;
    logic                out_flat_q, out_flat_d;
    logic                out_valid_q, out_valid_d;

    logic [SAMPLE_W-1:0] cmp_min, cmp_max;
    logic [SAMPLE_W-1:0] unused_min_hi, unused_max_lo;
    logic [SAMPLE_W-1:0] upd_min, upd_max;
    logic                accept;

    // One compare path narrows the running min, the other widens the running max.
    minmax4 u_min_path (
        .a  (run_min_q),
        .b  (in_data),
        .lo (cmp_min),
        .hi (unused_min_hi)
    );

    minmax4 u_max_path (
        .a  (run_max_q),
        .b  (in_data),
        .lo (unused_max_lo),
        .hi (cmp_max)
    );

    assign in_ready = (state_q == ACCUM) && !reset;
    assign accept   = in_valid && in_ready;

    // The first sample of a window seeds both extremes directly.
    assign upd_min = (cnt_q == '0) ? in_data : cmp_min;
    assign upd_max = (cnt_q == '0) ? in_data : cmp_max;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_flat_d  = out_flat_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    run_min_d = upd_min;
                    run_max_d = upd_max;
                    if (cnt_q == LAST) begin
                        out_min_d   = upd_min;
                        out_max_d   = upd_max;
                        out_flat_d  = (upd_min == upd_max);
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            run_min_q   <= '0;
            run_max_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_flat_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_flat_q  <= out_flat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_flat  = out_flat_q;
    assign out_valid = out_valid_q;

endmodule
